// File: rtl/nand_calib_pkg.sv
// ---------------------------------------------------------------------------
// nand_calib_pkg : shared types and constants for NAND DQS calibration
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package nand_calib_pkg;

  localparam int NAND_IDELAY_TAPS = 32;
  localparam int NAND_TAP_W       = 5;
  localparam logic [NAND_TAP_W-1:0] NAND_TAP_MAX = 5'(NAND_IDELAY_TAPS - 1);

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_TAP_RST    = 4'd1,
    ST_SETTLE     = 4'd2,
    ST_REQ        = 4'd3,
    ST_WAIT       = 4'd4,
    ST_STEP       = 4'd5,
    ST_CTR_RST    = 4'd6,
    ST_CTR_SETTLE = 4'd7,
    ST_CTR_STEP   = 4'd8,
    ST_DONE       = 4'd9,
    ST_ERR        = 4'd10
  } calib_state_t;

endpackage

`default_nettype wire

// File: rtl/nand_calib_cnt.sv
// ---------------------------------------------------------------------------
// nand_calib_cnt : loadable down-counter, saturates at zero
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module nand_calib_cnt #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic             zero
);

  logic [WIDTH-1:0] value;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (en && (value != '0)) begin
      value <= value - 1'b1;
    end
  end

  assign zero = (value == '0);

endmodule

`default_nettype wire

// File: rtl/nand_dqs_calib.sv
// ---------------------------------------------------------------------------
// nand_dqs_calib : DQS IDELAY tap sweep, first-window search and centring.
// Optional pass_map port: define NAND_DQS_CALIB_MAP_EN.   Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module nand_dqs_calib
  import nand_calib_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 16,
  parameter int MIN_WINDOW     = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                  clk0,
  input  logic                  rst0,
  input  logic                  calib_start,
  output logic                  train_req,
  input  logic                  train_done,
  input  logic                  train_pass,
  output logic                  dlyrst_dqs,
  output logic                  dlyce_dqs,
  output logic                  dlyinc_dqs,
  output logic [NAND_TAP_W-1:0] tap_cnt,
  output logic                  calib_busy,
  output logic                  calib_done,
  output logic                  calib_err,
  output logic [NAND_TAP_W-1:0] win_first,
  output logic [NAND_TAP_W-1:0] win_last
`ifdef NAND_DQS_CALIB_MAP_EN
  ,
  output logic [NAND_IDELAY_TAPS-1:0] pass_map
`endif
);

  calib_state_t          state;
  logic                  found;
  logic                  closed;
  logic [NAND_TAP_W-1:0] centre;

  logic settle_load, settle_en, settle_zero;
  logic tmo_load, tmo_en, tmo_zero;

  logic                  nxt_found;
  logic                  nxt_closed;
  logic [NAND_TAP_W-1:0] nxt_first;
  logic [NAND_TAP_W-1:0] nxt_last;
  logic [NAND_TAP_W:0]   nxt_width;
  logic [NAND_TAP_W:0]   nxt_sum;
  logic [NAND_TAP_W-1:0] nxt_centre;
  logic                  window_ok;

  always_comb begin
    settle_load = (state == ST_TAP_RST) || (state == ST_STEP) || (state == ST_CTR_RST);
    settle_en   = (state == ST_SETTLE) || (state == ST_CTR_SETTLE);
    tmo_load    = (state == ST_REQ);
    tmo_en      = (state == ST_WAIT);
  end

  nand_calib_cnt #(.WIDTH(8)) u_settle_cnt (
    .clk      (clk0),
    .rst      (rst0),
    .load     (settle_load),
    .load_val (8'(SETTLE_CYCLES - 1)),
    .en       (settle_en),
    .zero     (settle_zero)
  );

  nand_calib_cnt #(.WIDTH(16)) u_tmo_cnt (
    .clk      (clk0),
    .rst      (rst0),
    .load     (tmo_load),
    .load_val (16'(TIMEOUT_CYCLES - 1)),
    .en       (tmo_en),
    .zero     (tmo_zero)
  );

  // Window state as it will be after the current training result, so the
  // final tap can be evaluated in the same cycle its result arrives.
  always_comb begin
    nxt_found  = found;
    nxt_closed = closed;
    nxt_first  = win_first;
    nxt_last   = win_last;
    if (train_pass) begin
      if (!found) begin
        nxt_found = 1'b1;
        nxt_first = tap_cnt;
        nxt_last  = tap_cnt;
      end else if (!closed) begin
        nxt_last = tap_cnt;
      end
    end else if (found) begin
      nxt_closed = 1'b1;
    end
    nxt_width  = {1'b0, nxt_last} - {1'b0, nxt_first} + 6'd1;
    nxt_sum    = {1'b0, nxt_first} + {1'b0, nxt_last};
    nxt_centre = 5'(nxt_sum >> 1);
    window_ok  = nxt_found && (nxt_width >= 6'(MIN_WINDOW));
  end

  always_ff @(posedge clk0 or posedge rst0) begin
    if (rst0) begin
      state      <= ST_IDLE;
      train_req  <= 1'b0;
      dlyrst_dqs <= 1'b0;
      dlyce_dqs  <= 1'b0;
      dlyinc_dqs <= 1'b1;
      tap_cnt    <= '0;
      calib_busy <= 1'b0;
      calib_done <= 1'b0;
      calib_err  <= 1'b0;
      win_first  <= '0;
      win_last   <= '0;
      found      <= 1'b0;
      closed     <= 1'b0;
      centre     <= '0;
`ifdef NAND_DQS_CALIB_MAP_EN
      pass_map   <= '0;
`endif
    end else begin
      dlyrst_dqs <= 1'b0;
      dlyce_dqs  <= 1'b0;
      dlyinc_dqs <= 1'b1;
      case (state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (calib_start) begin
            state      <= ST_TAP_RST;
            calib_busy <= 1'b1;
            calib_done <= 1'b0;
            calib_err  <= 1'b0;
            win_first  <= '0;
            win_last   <= '0;
            found      <= 1'b0;
            closed     <= 1'b0;
            centre     <= '0;
`ifdef NAND_DQS_CALIB_MAP_EN
            pass_map   <= '0;
`endif
          end
        end
        ST_TAP_RST: begin
          dlyrst_dqs <= 1'b1;
          tap_cnt    <= '0;
          state      <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (settle_zero) begin
            train_req <= 1'b1;
            state     <= ST_REQ;
          end
        end
        ST_REQ: begin
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (train_done) begin
            train_req <= 1'b0;
            found     <= nxt_found;
            closed    <= nxt_closed;
            win_first <= nxt_first;
            win_last  <= nxt_last;
`ifdef NAND_DQS_CALIB_MAP_EN
            pass_map[tap_cnt] <= train_pass;
`endif
            if (tap_cnt != NAND_TAP_MAX) begin
              state <= ST_STEP;
            end else if (window_ok) begin
              centre <= nxt_centre;
              state  <= ST_CTR_RST;
            end else begin
              calib_busy <= 1'b0;
              calib_err  <= 1'b1;
              state      <= ST_ERR;
            end
          end else if (tmo_zero) begin
            train_req  <= 1'b0;
            calib_busy <= 1'b0;
            calib_err  <= 1'b1;
            state      <= ST_ERR;
          end
        end
        ST_STEP: begin
          dlyce_dqs <= 1'b1;
          tap_cnt   <= tap_cnt + 1'b1;
          state     <= ST_SETTLE;
        end
        ST_CTR_RST: begin
          dlyrst_dqs <= 1'b1;
          tap_cnt    <= '0;
          state      <= ST_CTR_SETTLE;
        end
        ST_CTR_SETTLE: begin
          if (settle_zero) begin
            if (centre == '0) begin
              calib_busy <= 1'b0;
              calib_done <= 1'b1;
              state      <= ST_DONE;
            end else begin
              state <= ST_CTR_STEP;
            end
          end
        end
        ST_CTR_STEP: begin
          if (tap_cnt == centre) begin
            calib_busy <= 1'b0;
            calib_done <= 1'b1;
            state      <= ST_DONE;
          end else begin
            dlyce_dqs <= 1'b1;
            tap_cnt   <= tap_cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_nand_dqs_calib.sv
// ---------------------------------------------------------------------------
// tb_nand_dqs_calib : directed bench with a latency-3 training sequencer model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_nand_dqs_calib;

  logic       clk0 = 1'b0;
  logic       rst0 = 1'b1;
  logic       calib_start = 1'b0;
  logic       train_done = 1'b0;
  logic       train_pass = 1'b0;
  logic       train_req, dlyrst_dqs, dlyce_dqs, dlyinc_dqs;
  logic [4:0] tap_cnt, win_first, win_last;
  logic       calib_busy, calib_done, calib_err;
`ifdef NAND_DQS_CALIB_MAP_EN
  logic [31:0] pass_map;
`endif

  nand_dqs_calib dut (
    .clk0        (clk0),
    .rst0        (rst0),
    .calib_start (calib_start),
    .train_req   (train_req),
    .train_done  (train_done),
    .train_pass  (train_pass),
    .dlyrst_dqs  (dlyrst_dqs),
    .dlyce_dqs   (dlyce_dqs),
    .dlyinc_dqs  (dlyinc_dqs),
    .tap_cnt     (tap_cnt),
    .calib_busy  (calib_busy),
    .calib_done  (calib_done),
    .calib_err   (calib_err),
    .win_first   (win_first),
    .win_last    (win_last)
`ifdef NAND_DQS_CALIB_MAP_EN
    ,
    .pass_map    (pass_map)
`endif
  );

  always #5 clk0 = ~clk0;

  int errors = 0;
  int checks = 0;
  logic [31:0] mask = '0;
  int hang_tap = -1;
  int lat_cnt = 0;
  int ce_n = 0, rst_n = 0, both_n = 0, bad_ce = 0, req6 = 0;

  // Sequencer model: answers three cycles after train_req rises.
  always @(negedge clk0) begin
    if (train_req && !train_done) begin
      lat_cnt = lat_cnt + 1;
      if (lat_cnt == 3 && tap_cnt != hang_tap) begin
        train_done = 1'b1;
        train_pass = mask[tap_cnt];
      end
    end else begin
      train_done = 1'b0;
      train_pass = 1'b0;
      lat_cnt    = 0;
    end
  end

  always @(negedge clk0) begin
    if (!rst0) begin
      if (dlyce_dqs) ce_n = ce_n + 1;
      if (dlyrst_dqs) rst_n = rst_n + 1;
      if (dlyce_dqs && dlyrst_dqs) both_n = both_n + 1;
      if (dlyce_dqs && tap_cnt == 5'd0) bad_ce = bad_ce + 1;
      if (train_req && tap_cnt == 5'd6) req6 = req6 + 1;
    end
  end

  task automatic clear_counts;
    ce_n = 0; rst_n = 0; both_n = 0; bad_ce = 0; req6 = 0;
  endtask

  task automatic start_cal;
    @(negedge clk0) calib_start = 1'b1;
    @(negedge clk0) calib_start = 1'b0;
  endtask

  task automatic wait_end(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk0);
      if (calib_done || calib_err) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst0 = 1'b1;
    repeat (3) @(negedge clk0);
    checks++;
    if ({train_req, dlyrst_dqs, dlyce_dqs, dlyinc_dqs, calib_busy, calib_done, calib_err} !== 7'b0001000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 0001000",
               {train_req, dlyrst_dqs, dlyce_dqs, dlyinc_dqs, calib_busy, calib_done, calib_err});
    end
    checks++;
    if ({tap_cnt, win_first, win_last} !== 15'd0) begin
      errors++;
      $display("FAIL reset_taps: got tap=%0d first=%0d last=%0d expected all 0", tap_cnt, win_first, win_last);
    end
    rst0 = 1'b0;
    @(negedge clk0);
  endtask

  task automatic test_window;
    bit ok;
    mask = 32'h003F_FC00;
    hang_tap = -1;
    clear_counts();
    start_cal();
    checks++;
    if (calib_busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_rise: got %b expected 1", calib_busy);
    end
    wait_end(ok);
    checks++;
    if (!ok || calib_done !== 1'b1 || calib_err !== 1'b0) begin
      errors++;
      $display("FAIL win_done: got done=%b err=%b expected done=1 err=0", calib_done, calib_err);
    end
    checks++;
    if (win_first !== 5'd10 || win_last !== 5'd21) begin
      errors++;
      $display("FAIL win_edges: got %0d..%0d expected 10..21", win_first, win_last);
    end
    checks++;
    if (tap_cnt !== 5'd15) begin
      errors++;
      $display("FAIL win_tap: got %0d expected 15", tap_cnt);
    end
    // 31 sweep steps plus 15 centring steps; one reset for sweep, one for centring
    checks++;
    if (ce_n != 46 || rst_n != 2 || both_n != 0) begin
      errors++;
      $display("FAIL win_pulses: got ce=%0d rst=%0d both=%0d expected 46 2 0", ce_n, rst_n, both_n);
    end
    checks++;
    if (calib_busy !== 1'b0) begin
      errors++;
      $display("FAIL win_busy: got %b expected 0", calib_busy);
    end
  endtask

  task automatic test_short_window;
    bit ok;
    mask = 32'h7FF0_0038;
    clear_counts();
    start_cal();
    wait_end(ok);
    checks++;
    if (!ok || calib_err !== 1'b1 || calib_done !== 1'b0) begin
      errors++;
      $display("FAIL short_err: got done=%b err=%b expected done=0 err=1", calib_done, calib_err);
    end
    checks++;
    if (win_first !== 5'd3 || win_last !== 5'd5) begin
      errors++;
      $display("FAIL short_edges: got %0d..%0d expected 3..5", win_first, win_last);
    end
    checks++;
    if (tap_cnt !== 5'd31 || ce_n != 31 || rst_n != 1) begin
      errors++;
      $display("FAIL short_sweep: got tap=%0d ce=%0d rst=%0d expected 31 31 1", tap_cnt, ce_n, rst_n);
    end
  endtask

  task automatic test_all_pass;
    bit ok;
    mask = 32'hFFFF_FFFF;
    clear_counts();
    start_cal();
    wait_end(ok);
    checks++;
    if (!ok || calib_done !== 1'b1 || win_first !== 5'd0 || win_last !== 5'd31) begin
      errors++;
      $display("FAIL all_window: got done=%b %0d..%0d expected done=1 0..31", calib_done, win_first, win_last);
    end
    checks++;
    if (tap_cnt !== 5'd15 || bad_ce != 0 || ce_n != 46) begin
      errors++;
      $display("FAIL all_centre: got tap=%0d wraps=%0d ce=%0d expected 15 0 46", tap_cnt, bad_ce, ce_n);
    end
  endtask

  task automatic test_timeout;
    bit ok;
    mask = 32'h003F_FC00;
    hang_tap = 6;
    clear_counts();
    start_cal();
    wait_end(ok);
    checks++;
    if (!ok || calib_err !== 1'b1 || train_req !== 1'b0 || tap_cnt !== 5'd6) begin
      errors++;
      $display("FAIL tmo_state: got err=%b req=%b tap=%0d expected 1 0 6", calib_err, train_req, tap_cnt);
    end
    // train_req spans the REQ cycle plus 4096 WAIT cycles
    checks++;
    if (req6 != 4097) begin
      errors++;
      $display("FAIL tmo_length: got %0d req cycles expected 4097", req6);
    end
    hang_tap = -1;
  endtask

  task automatic test_reset_mid;
    bit ok;
    bit hit;
    mask = 32'h003F_FC00;
    start_cal();
    hit = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk0);
      if (train_req && tap_cnt == 5'd12) begin
        hit = 1'b1;
        break;
      end
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL mid_reach: got no request at tap 12 expected one");
    end
    @(negedge clk0);
    #2 rst0 = 1'b1;
    #1;
    checks++;
    if ({train_req, dlyrst_dqs, dlyce_dqs, calib_busy, calib_done, calib_err} !== 6'b0 || tap_cnt !== 5'd0) begin
      errors++;
      $display("FAIL mid_async: got req=%b busy=%b tap=%0d expected 0 0 0", train_req, calib_busy, tap_cnt);
    end
    @(negedge clk0) rst0 = 1'b0;
    clear_counts();
    start_cal();
    wait_end(ok);
    checks++;
    if (!ok || calib_done !== 1'b1 || tap_cnt !== 5'd15 || ce_n != 46 || rst_n != 2) begin
      errors++;
      $display("FAIL mid_recal: got done=%b tap=%0d ce=%0d rst=%0d expected 1 15 46 2",
               calib_done, tap_cnt, ce_n, rst_n);
    end
  endtask

`ifdef NAND_DQS_CALIB_MAP_EN
  task automatic test_pass_map;
    bit ok;
    mask = 32'h000F_FF00;
    start_cal();
    wait_end(ok);
    checks++;
    if (!ok || pass_map !== 32'h000F_FF00 || tap_cnt !== 5'd13) begin
      errors++;
      $display("FAIL map_value: got map=%h tap=%0d expected 000fff00 13", pass_map, tap_cnt);
    end
    start_cal();
    checks++;
    if (pass_map !== 32'h0) begin
      errors++;
      $display("FAIL map_clear: got %h expected 00000000", pass_map);
    end
    wait_end(ok);
  endtask
`endif

  initial begin
    test_reset();
    test_window();
    test_short_window();
    test_all_pass();
    test_timeout();
    test_reset_mid();
`ifdef NAND_DQS_CALIB_MAP_EN
    test_pass_map();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
